// File: rtl/tmds_deserializer_if.sv
// tmds_deserializer_if: serial input and aligned word output of one TMDS channel deserializer
interface tmds_deserializer_if;
  logic       din;
  logic [9:0] dout;
  logic       valid;
  logic       is_token;
  logic       locked;
  modport master (output din, input dout, valid, is_token, locked);
  modport slave (input din, output dout, valid, is_token, locked);
endinterface

// File: rtl/tmds_deserializer.sv
// tmds_deserializer: bit-clock TMDS channel deserializer with control-token word alignment
module tmds_deserializer #(
  parameter int LOCK_COUNT    = 4,
  parameter int TIMEOUT_WORDS = 4096,
  parameter int TW            = 13
) (
  input logic               clk,
  input logic               rst,
  tmds_deserializer_if.slave bus
);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [1:0] SEARCH = 2'd0, CONFIRM = 2'd1, LOCKED = 2'd2;
  logic [9:0]    sr;
  logic [3:0]    ph;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [1:0]    state;
  logic          match, bnd;
  assign match = sr == 10'h354 || sr == 10'h0AB || sr == 10'h154 || sr == 10'h2AB;
  assign bnd = ph == 4'd0;
  assign cnt_nx = cnt + 1'b1;
  assign tcnt_nx = tcnt + 1'b1;
  assign bus.locked = state == LOCKED;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      ph <= '0;
      cnt <= '0;
      tcnt <= '0;
      state <= SEARCH;
      bus.dout <= '0;
      bus.valid <= 1'b0;
      bus.is_token <= 1'b0;
    end else begin
      sr <= {bus.din, sr[9:1]};
      ph <= ph == 4'd9 ? 4'd0 : ph + 1'b1;
      bus.valid <= 1'b0;
      case (state)
        SEARCH: if (match) begin
          // the matching cycle is treated as the boundary, so the next word lands on ph==0
          ph <= 4'd1;
          cnt <= CW'(1);
          tcnt <= '0;
          state <= LOCK_COUNT == 1 ? LOCKED : CONFIRM;
        end
        CONFIRM: if (bnd) begin
          if (match) begin
            cnt <= cnt_nx;
            if (cnt_nx == CW'(LOCK_COUNT)) begin
              state <= LOCKED;
              tcnt <= '0;
            end
          end else begin
            cnt <= '0;
            state <= SEARCH;
          end
        end
        LOCKED: if (bnd) begin
          bus.dout <= sr;
          bus.valid <= 1'b1;
          bus.is_token <= match;
          if (match) tcnt <= '0;
          else begin
            tcnt <= tcnt_nx;
            if (tcnt_nx == TW'(TIMEOUT_WORDS)) begin
              state <= SEARCH;
              cnt <= '0;
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end
endmodule
